// File: rtl/fpu_lzc48.sv
// fpu_lzc48: registered 48-bit leading-zero counter with valid tagging.
// Define FPU_LZC_NORM_EN to add the registered normalized output norm_out.
module fpu_lzc48 #(
    parameter int WIDTH = 48,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [CW-1:0]    count,
    output logic             zero
`ifdef FPU_LZC_NORM_EN
    ,
    output logic [WIDTH-1:0] norm_out
`endif
);

    localparam int PW_RAW = 1 << $clog2(WIDTH);
    localparam int PW     = (PW_RAW < 4) ? 4 : PW_RAW;
    localparam int NN     = PW / 4;
    localparam int LV     = $clog2(NN);
    localparam int TW     = $clog2(PW) + 1;

    // Node 0 is the most significant nibble; each merge pairs hi=2j, lo=2j+1.
    // An all-zero node reports its full size so merges need no extra flag.
    function automatic logic [TW-1:0] tree_lzc(input logic [PW-1:0] x);
        logic [TW-1:0] c [NN];
        logic          v [NN];
        logic [3:0]    nib;
        for (int n = 0; n < NN; n++) begin
            nib  = x[PW-1-4*n -: 4];
            v[n] = |nib;
            casez (nib)
                4'b1???: c[n] = TW'(0);
                4'b01??: c[n] = TW'(1);
                4'b001?: c[n] = TW'(2);
                4'b0001: c[n] = TW'(3);
                default: c[n] = TW'(4);
            endcase
        end
        for (int l = 0; l < LV; l++) begin
            for (int j = 0; j < (NN >> (l + 1)); j++) begin
                c[j] = v[2*j] ? c[2*j] : (c[2*j+1] + TW'(4 << l));
                v[j] = v[2*j] | v[2*j+1];
            end
        end
        return c[0];
    endfunction

    logic [PW-1:0]    padded;
    logic [TW-1:0]    tree_cnt;
    logic             zero_d;
    logic [CW-1:0]    count_d;

    // Ones below the LSB stop the scan at WIDTH without touching real counts.
    always_comb begin
        padded                 = '1;
        padded[PW-1 -: WIDTH]  = data_in;
        tree_cnt               = tree_lzc(padded);
        zero_d                 = ~|data_in;
        count_d                = zero_d ? CW'(WIDTH) : CW'(tree_cnt);
    end

`ifdef FPU_LZC_NORM_EN
    logic [WIDTH-1:0] norm_d;

    always_comb begin
        norm_d = data_in << count_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            count     <= '0;
            zero      <= 1'b0;
`ifdef FPU_LZC_NORM_EN
            norm_out  <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                count    <= count_d;
                zero     <= zero_d;
`ifdef FPU_LZC_NORM_EN
                norm_out <= norm_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fpu_lzc48.sv
// tb_fpu_lzc48: directed and randomized checks of fpu_lzc48
// against a bit-scanning reference model.
module tb_fpu_lzc48;

    localparam int W  = 48;
    localparam int CW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          zero;
`ifdef FPU_LZC_NORM_EN
    logic [W-1:0]  norm_out;
`endif

    int n_pass;
    int n_total;

    fpu_lzc48 #(.WIDTH(W), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .data_in  (data_in),
        .out_valid(out_valid),
        .count    (count),
        .zero     (zero)
`ifdef FPU_LZC_NORM_EN
        ,
        .norm_out (norm_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_lzc(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return W - 1 - i;
        return W;
    endfunction

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic drive(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 48'h1);
            n_total++;
            if (out_valid !== 1'b0 || count !== 6'd0 || zero !== 1'b0)
                $display("FAIL reset[%0d]: got v=%b c=%0d z=%b want v=0 c=0 z=0",
                         i, out_valid, count, zero);
            else n_pass++;
`ifdef FPU_LZC_NORM_EN
            n_total++;
            if (norm_out !== '0)
                $display("FAIL reset_norm[%0d]: got %h want 0", i, norm_out);
            else n_pass++;
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 48'h1);
        n_total++;
        if (out_valid !== 1'b1 || count !== 6'd47 || zero !== 1'b0)
            $display("FAIL first_after_reset: got v=%b c=%0d z=%b want v=1 c=47 z=0",
                     out_valid, count, zero);
        else n_pass++;
    endtask

    task automatic test_sweep();
        for (int k = W - 1; k >= 0; k--) begin
            logic [W-1:0] d;
            d = '0;
            d[k] = 1'b1;
            drive(1'b1, d);
            n_total++;
            if (out_valid !== 1'b1 || count !== CW'(47 - k) || zero !== 1'b0)
                $display("FAIL sweep k=%0d: got v=%b c=%0d z=%b want v=1 c=%0d z=0",
                         k, out_valid, count, zero, 47 - k);
            else n_pass++;
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] pat [11];
        int           exp [11];
        pat[0]  = 48'h000000000000; exp[0]  = 48;
        pat[1]  = 48'hFFFFFFFFFFFF; exp[1]  = 0;
        pat[2]  = 48'hAAAAAAAAAAAA; exp[2]  = 0;
        pat[3]  = 48'h800000000001; exp[3]  = 0;
        pat[4]  = 48'h0000000000FF; exp[4]  = 40;
        pat[5]  = 48'h00000000FFFF; exp[5]  = 32;
        pat[6]  = 48'h0000FFFFFFFF; exp[6]  = 16;
        pat[7]  = 48'h000000001234; exp[7]  = 35;
        pat[8]  = 48'h000080000000; exp[8]  = 16;
        pat[9]  = 48'h000000000001; exp[9]  = 47;
        pat[10] = 48'h400000000000; exp[10] = 1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, pat[i]);
            n_total++;
            if (out_valid !== 1'b1 || count !== CW'(exp[i]) ||
                zero !== (exp[i] == 48))
                $display("FAIL pattern %h: got v=%b c=%0d z=%b want v=1 c=%0d z=%b",
                         pat[i], out_valid, count, zero, exp[i], exp[i] == 48);
            else n_pass++;
        end
`ifdef FPU_LZC_NORM_EN
        drive(1'b1, 48'h000000001234);
        n_total++;
        if (norm_out !== 48'h91A000000000)
            $display("FAIL norm_1234: got %h want 91a000000000", norm_out);
        else n_pass++;
        drive(1'b1, 48'h0);
        n_total++;
        if (norm_out !== 48'h0 || zero !== 1'b1)
            $display("FAIL norm_zero: got n=%h z=%b want n=0 z=1", norm_out, zero);
        else n_pass++;
`endif
    endtask

    task automatic test_valid_gating();
        drive(1'b1, 48'h000000800000);
        n_total++;
        if (out_valid !== 1'b1 || count !== 6'd24 || zero !== 1'b0)
            $display("FAIL gate_load: got v=%b c=%0d z=%b want v=1 c=24 z=0",
                     out_valid, count, zero);
        else n_pass++;
        drive(1'b0, 48'h0);
        n_total++;
        if (out_valid !== 1'b0 || count !== 6'd24 || zero !== 1'b0)
            $display("FAIL gate_hold: got v=%b c=%0d z=%b want v=0 c=24 z=0",
                     out_valid, count, zero);
        else n_pass++;
    endtask

    // Random valid/data stream; model keeps the last accepted result.
    task automatic test_back_to_back();
        int           e_cnt;
        logic         e_zero;
        logic [W-1:0] e_norm;
        e_cnt  = ref_lzc(48'h0);
        e_zero = 1'b1;
        e_norm = '0;
        drive(1'b1, 48'h0);
        for (int i = 0; i < 400; i++) begin
            logic         v;
            logic [W-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom} >> $urandom_range(0, 49);
            if (v) begin
                e_cnt  = ref_lzc(d);
                e_zero = (d == '0);
                e_norm = (e_cnt == W) ? '0 : (d << e_cnt);
            end
            drive(v, d);
            n_total++;
            if (out_valid !== v || count !== CW'(e_cnt) || zero !== e_zero)
                $display("FAIL rand[%0d] d=%h v=%b: got v=%b c=%0d z=%b want c=%0d z=%b",
                         i, d, v, out_valid, count, zero, e_cnt, e_zero);
            else n_pass++;
`ifdef FPU_LZC_NORM_EN
            n_total++;
            if (norm_out !== e_norm)
                $display("FAIL rand_norm[%0d]: got %h want %h", i, norm_out, e_norm);
            else n_pass++;
`else
            e_norm = '0;
`endif
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        test_reset();
        test_sweep();
        test_patterns();
        test_valid_gating();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
